// File: rtl/ad100_pkg.sv
// Shared types and constants for the ad100 memory arbiter: widths, port ids
// and the owner-state encoding.
package ad100_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1,
    StOwn1Locked
  } owner_state_e;

  // Owner state entered when `port` transfers; `lock` is req1_lock for a DMA transfer.
  function automatic owner_state_e port_state(input logic port, input logic lock);
    if (port == PORT_DMA) begin
      return lock ? StOwn1Locked : StOwn1;
    end
    return StOwn0;
  endfunction

endpackage

// File: rtl/ad100_rr_select.sv
// Two-input round-robin winner picker with a DMA lock override; purely
// combinational, one-hot grant.
module ad100_rr_select
  import ad100_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       locked_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (locked_i && valid_i[PORT_DMA]) begin
      grant_o = 2'b10;
    end else if (&valid_i) begin
      // On a tie the port that did not win last time goes first.
      grant_o = (last_grant_i == PORT_DMA) ? 2'b01 : 2'b10;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/ad100_mem_arbiter.sv
// Shares one synchronous single-port RAM between the ad100 CPU data port (0)
// and the loader/debug DMA port (1); read data returns one cycle later.
module ad100_mem_arbiter
  import ad100_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W,
  parameter int unsigned DataW = DATA_W,
  localparam int unsigned BeW  = DataW / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [AddrW-1:0] req0_addr_i,
  input  logic             req0_we_i,
  input  logic [BeW-1:0]   req0_be_i,
  input  logic [DataW-1:0] req0_wdata_i,
  output logic             rsp0_valid_o,
  output logic [DataW-1:0] rsp0_rdata_o,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [AddrW-1:0] req1_addr_i,
  input  logic             req1_we_i,
  input  logic [BeW-1:0]   req1_be_i,
  input  logic [DataW-1:0] req1_wdata_i,
  input  logic             req1_lock_i,
  output logic             rsp1_valid_o,
  output logic [DataW-1:0] rsp1_rdata_o,

  output logic             mem_en_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [BeW-1:0]   mem_we_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic [DataW-1:0] mem_rdata_i
);

  logic [1:0]   sel_grant, grant;
  logic         xfer, win, win_we;
  logic         last_grant_q, last_grant_d;
  logic         locked_q, locked_d;
  logic         rsp_pend_q, rsp_pend_d;
  logic         rsp_owner_q, rsp_owner_d;
  logic         rsp_we_q, rsp_we_d;
  logic         rsp_live;
  logic [DataW-1:0] rsp_data;
  owner_state_e state_q, state_d;

  ad100_rr_select u_rr_select (
    .valid_i      ({req1_valid_i, req0_valid_i}),
    .last_grant_i (last_grant_q),
    .locked_i     (locked_q),
    .grant_o      (sel_grant)
  );

  // Nothing is accepted while reset is held.
  assign grant        = rst_ni ? sel_grant : 2'b00;
  assign req0_ready_o = grant[PORT_CPU];
  assign req1_ready_o = grant[PORT_DMA];
  assign xfer         = |grant;
  assign win          = grant[PORT_DMA];

  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = '0;
    mem_wdata_o = '0;
    win_we      = 1'b0;
    if (xfer) begin
      mem_en_o = 1'b1;
      if (win == PORT_DMA) begin
        mem_addr_o  = req1_addr_i;
        mem_wdata_o = req1_wdata_i;
        mem_we_o    = req1_be_i & {BeW{req1_we_i}};
        win_we      = req1_we_i;
      end else begin
        mem_addr_o  = req0_addr_i;
        mem_wdata_o = req0_wdata_i;
        mem_we_o    = req0_be_i & {BeW{req0_we_i}};
        win_we      = req0_we_i;
      end
    end
  end

  always_comb begin
    last_grant_d = xfer ? win : last_grant_q;
    locked_d     = req1_lock_i ? (locked_q | grant[PORT_DMA]) : 1'b0;
    rsp_pend_d   = xfer;
    rsp_owner_d  = win;
    rsp_we_d     = win_we;

    state_d = state_q;
    if (xfer) begin
      state_d = port_state(win, req1_lock_i);
    end else if ((state_q == StOwn1Locked) && !req1_lock_i) begin
      state_d = StOwn1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= PORT_DMA;
      locked_q     <= 1'b0;
      rsp_pend_q   <= 1'b0;
      rsp_owner_q  <= PORT_CPU;
      rsp_we_q     <= 1'b0;
      state_q      <= StIdle;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_we_q     <= rsp_we_d;
      state_q      <= state_d;
    end
  end

  // A response still pending when reset arrives is suppressed, not delivered.
  assign rsp_live     = rsp_pend_q & rst_ni;
  assign rsp_data     = rsp_we_q ? '0 : mem_rdata_i;
  assign rsp0_valid_o = rsp_live && (rsp_owner_q == PORT_CPU);
  assign rsp1_valid_o = rsp_live && (rsp_owner_q == PORT_DMA);
  assign rsp0_rdata_o = rsp0_valid_o ? rsp_data : '0;
  assign rsp1_rdata_o = rsp1_valid_o ? rsp_data : '0;

endmodule

// File: tb/tb_ad100_mem_arbiter.sv
// Directed bench for ad100_mem_arbiter with a small byte-writable RAM model.
module tb_ad100_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_we;
  logic [29:0] req0_addr;
  logic [3:0]  req0_be;
  logic [31:0] req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [29:0] req1_addr;
  logic [3:0]  req1_be;
  logic [31:0] req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ad100_mem_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_addr_i  (req0_addr),
    .req0_we_i    (req0_we),
    .req0_be_i    (req0_be),
    .req0_wdata_i (req0_wdata),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_rdata_o (rsp0_rdata),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_addr_i  (req1_addr),
    .req1_we_i    (req1_we),
    .req1_be_i    (req1_be),
    .req1_wdata_i (req1_wdata),
    .req1_lock_i  (req1_lock),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_rdata_o (rsp1_rdata),
    .mem_en_o     (mem_en),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // RAM model: cleared while reset is held, read data registered one cycle.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_addr = '0; req0_we = 1'b0; req0_be = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_we = 1'b0; req1_be = '0; req1_wdata = '0;
    req1_lock  = 1'b0;
  endtask

  task automatic set0(input logic [29:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] d);
    req0_valid = 1'b1; req0_addr = a; req0_we = we; req0_be = be; req0_wdata = d;
  endtask

  task automatic set1(input logic [29:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] d, input logic lock);
    req1_valid = 1'b1; req1_addr = a; req1_we = we; req1_be = be; req1_wdata = d;
    req1_lock = lock;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    set0(30'h1, 1'b0, 4'hF, 32'h0);
    set1(30'h2, 1'b1, 4'hF, 32'h55, 1'b0);
    step();
    n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_vec++; if (mem_we !== 4'h0) begin n_err++; $display("FAIL rst_mem_we: got %h want 0", mem_we); end
    n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    n_vec++; if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", {rsp0_rdata, rsp1_rdata}); end
    step();
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_port0_rw();
    set0(30'h10, 1'b1, 4'b0011, 32'hDEADBEEF);
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL p0_wr_ready: got %b want 1", req0_ready); end
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 30'h10) begin n_err++; $display("FAIL p0_wr_mem: got en=%b addr=%h want en=1 addr=10", mem_en, mem_addr); end
    n_vec++; if (mem_we !== 4'b0011) begin n_err++; $display("FAIL p0_wr_we: got %b want 0011", mem_we); end
    n_vec++; if (mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL p0_wr_wdata: got %h want deadbeef", mem_wdata); end
    step();
    set0(30'h10, 1'b0, 4'hF, 32'h0);
    #1;
    n_vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0) begin n_err++; $display("FAIL p0_wr_rsp: got v=%b d=%h want v=1 d=0", rsp0_valid, rsp0_rdata); end
    n_vec++; if (mem_en !== 1'b1 || mem_we !== 4'h0) begin n_err++; $display("FAIL p0_rd_mem: got en=%b we=%b want en=1 we=0000", mem_en, mem_we); end
    step();
    idle();
    #1;
    n_vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0000BEEF) begin n_err++; $display("FAIL p0_rd_rsp: got v=%b d=%h want v=1 d=0000beef", rsp0_valid, rsp0_rdata); end
    n_vec++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL p0_rd_rsp1: got %b want 0", rsp1_valid); end
    n_vec++; if (mem_en !== 1'b0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL idle_mem: got en=%b addr=%h wd=%h want 0", mem_en, mem_addr, mem_wdata); end
    step();
    n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL p0_rsp_once: got %b want 0", rsp0_valid); end
  endtask

  task automatic test_contention();
    logic e0, e1, p0, p1;
    apply_reset();
    set0(30'h1, 1'b0, 4'hF, 32'h0);
    set1(30'h2, 1'b0, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e0 = (i % 2 == 0);
      e1 = !e0;
      #1;
      n_vec++; if ({req1_ready, req0_ready} !== {e1, e0}) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, {e1, e0}); end
      if (i > 0) begin
        p0 = ((i - 1) % 2 == 0);
        p1 = !p0;
        n_vec++; if ({rsp1_valid, rsp0_valid} !== {p1, p0}) begin n_err++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, {rsp1_valid, rsp0_valid}, {p1, p0}); end
      end
      step();
    end
    idle();
    #1;
    n_vec++; if ({rsp1_valid, rsp0_valid} !== 2'b10 || rsp0_rdata !== 32'h0) begin n_err++; $display("FAIL rr_last_rsp: got v=%b d0=%h want v=10 d0=0", {rsp1_valid, rsp0_valid}, rsp0_rdata); end
    step();
  endtask

  task automatic test_lock();
    set0(30'h3, 1'b0, 4'hF, 32'h0);
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL lk_pre: got %b want 1", req0_ready); end
    step();
    set1(30'h4, 1'b0, 4'hF, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL lk_grant[%0d]: got %b want 10", i, {req1_ready, req0_ready}); end
      step();
    end
    req1_valid = 1'b0;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL lk_p0_gap: got %b want 1", req0_ready); end
    step();
    req1_valid = 1'b1;
    #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL lk_resume: got %b want 10", {req1_ready, req0_ready}); end
    step();
    idle();
    step();
    set0(30'h3, 1'b0, 4'hF, 32'h0);
    set1(30'h4, 1'b0, 4'hF, 32'h0, 1'b0);
    #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL lk_release: got %b want 01", {req1_ready, req0_ready}); end
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    set1(30'h20, 1'b1, 4'hF, 32'h12345678, 1'b0);
    step();
    set1(30'h20, 1'b0, 4'hF, 32'h0, 1'b0);
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rd_ready: got %b want 1", req1_ready); end
    step();
    idle();
    set0(30'h30, 1'b1, 4'hF, 32'hCAFEF00D);
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready: got %b want 1", req0_ready); end
    n_vec++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h12345678) begin n_err++; $display("FAIL b2b_rsp1: got v=%b d=%h want v=1 d=12345678", rsp1_valid, rsp1_rdata); end
    n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL b2b_rsp0_quiet: got %b want 0", rsp0_valid); end
    step();
    idle();
    #1;
    n_vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0) begin n_err++; $display("FAIL b2b_wr_rsp: got v=%b d=%h want v=1 d=0", rsp0_valid, rsp0_rdata); end
    step();
  endtask

  task automatic test_reset_drop();
    set0(30'h30, 1'b0, 4'hF, 32'h0);
    step();
    rst_n = 1'b0;
    set1(30'h31, 1'b0, 4'hF, 32'h0, 1'b0);
    #1;
    n_vec++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 32'h0) begin n_err++; $display("FAIL rd_drop_rsp: got v=%b d=%h want 0", rsp0_valid, rsp0_rdata); end
    n_vec++; if ({req1_ready, req0_ready, mem_en} !== 3'b000) begin n_err++; $display("FAIL rd_drop_out: got %b want 000", {req1_ready, req0_ready, mem_en}); end
    step();
    rst_n = 1'b1;
    #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL rd_drop_tie: got %b want 01", {req1_ready, req0_ready}); end
    n_vec++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_err++; $display("FAIL rd_drop_pend: got %b want 00", {rsp1_valid, rsp0_valid}); end
    step();
    idle();
    step();
  endtask

  task automatic test_be_zero();
    set1(30'h40, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b0);
    step();
    set1(30'h40, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0);
    #1;
    n_vec++; if (req1_ready !== 1'b1 || mem_en !== 1'b1) begin n_err++; $display("FAIL be0_xfer: got rdy=%b en=%b want 1 1", req1_ready, mem_en); end
    n_vec++; if (mem_we !== 4'h0 || mem_addr !== 30'h40) begin n_err++; $display("FAIL be0_mem: got we=%b addr=%h want 0000 40", mem_we, mem_addr); end
    step();
    idle();
    #1;
    n_vec++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h0) begin n_err++; $display("FAIL be0_rsp: got v=%b d=%h want v=1 d=0", rsp1_valid, rsp1_rdata); end
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_port0_rw();
    test_contention();
    test_lock();
    test_back_to_back();
    test_reset_drop();
    test_be_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
